// File: rtl/ddr3_ise_read.sv
// ----------------------------------------------------------------------------
// ddr3_ise_read
//   Read-side user-port master for the Spartan-6 MIG DDR3 port 0 (c3_p0).
//   After calibration completes (prepareFin), the block walks the address
//   space in fixed bursts. For each burst it issues one read command, drains
//   BURST_LEN words from the MIG read FIFO, and presents each word on a
//   valid-strobed output. Addresses step exactly as on the write-side master,
//   so the memory image is read back in the order it was written.
//
//   Optional feature: define DDR3_READ_CHECK_EN to compare every burst word
//   against an incrementing pattern (1, 2, 3, ...). Mismatches are counted in
//   error_count, which saturates. With the macro undefined, error_count is
//   tied to 0.
//
// Ports
//   clock                in   MIG user clock
//   reset                in   synchronous, active-high reset
//   prepareFin           in   calibration done; low forces IDLE
//   c3_p0_cmd_en         out  one-cycle command strobe
//   c3_p0_cmd_instr      out  constant read instruction (3'b001)
//   c3_p0_cmd_bl         out  constant burst length minus one
//   c3_p0_cmd_byte_addr  out  burst start byte address
//   c3_p0_cmd_full       in   command FIFO full
//   c3_p0_rd_en          out  read-FIFO pop (combinational)
//   c3_p0_rd_data        in   read-FIFO head word (first-word-fall-through)
//   c3_p0_rd_empty       in   read FIFO empty
//   c3_p0_rd_overflow    in   read FIFO overflow
//   data_out             out  last captured burst word
//   data_valid           out  one-cycle strobe per data_out word
//   pass_done            out  one-cycle pulse when the walk wraps to 0
//   timeout_flag         out  sticky: a word wait exceeded TIMEOUT cycles
//   overflow_flag        out  sticky: read FIFO overflow was seen
//   error_count          out  pattern mismatch count (check build only)
// ----------------------------------------------------------------------------
module ddr3_ise_read #(
    parameter int          BURST_LEN  = 4,
    parameter int          ADDR_STEP  = 64,
    parameter logic [29:0] ADDR_LIMIT = 30'h4000,
    parameter int          TIMEOUT    = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        prepareFin,
    output logic        c3_p0_cmd_en,
    output logic [2:0]  c3_p0_cmd_instr,
    output logic [5:0]  c3_p0_cmd_bl,
    output logic [29:0] c3_p0_cmd_byte_addr,
    input  logic        c3_p0_cmd_full,
    output logic        c3_p0_rd_en,
    input  logic [63:0] c3_p0_rd_data,
    input  logic        c3_p0_rd_empty,
    input  logic        c3_p0_rd_overflow,
    output logic [63:0] data_out,
    output logic        data_valid,
    output logic        pass_done,
    output logic        timeout_flag,
    output logic        overflow_flag,
    output logic [15:0] error_count
);

    localparam int WCNT_W = $clog2(BURST_LEN + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        NEXT
    } state_t;

    state_t              state;
    logic [29:0]         addr;
    logic [WCNT_W-1:0]   wcnt;
    logic [TCNT_W-1:0]   tcnt;
    logic [30:0]         addr_sum;
    logic                addr_wrap;

    assign c3_p0_cmd_instr = 3'b001;
    assign c3_p0_cmd_bl    = 6'(BURST_LEN - 1);

    // Popping is allowed while flushing in IDLE and while draining a burst in
    // WAIT. The pop stops in the same cycle prepareFin drops.
    assign c3_p0_rd_en = prepareFin && !c3_p0_rd_empty &&
                         ((state == IDLE) || (state == WAIT));

    // One extra adder bit keeps the wrap compare correct near the top of the
    // 30-bit byte-address space.
    assign addr_sum  = {1'b0, addr} + 31'(ADDR_STEP);
    assign addr_wrap = (addr_sum >= {1'b0, ADDR_LIMIT});

`ifdef DDR3_READ_CHECK_EN
    logic [63:0] expected;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`else
    assign error_count = 16'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            addr                <= '0;
            wcnt                <= '0;
            tcnt                <= '0;
            c3_p0_cmd_en        <= 1'b0;
            c3_p0_cmd_byte_addr <= '0;
            data_out            <= '0;
            data_valid          <= 1'b0;
            pass_done           <= 1'b0;
            timeout_flag        <= 1'b0;
            overflow_flag       <= 1'b0;
`ifdef DDR3_READ_CHECK_EN
            expected            <= 64'd1;
            error_count         <= 16'd0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            c3_p0_cmd_en  <= 1'b0;
            data_valid    <= 1'b0;
            pass_done     <= 1'b0;
            overflow_flag <= overflow_flag | c3_p0_rd_overflow;

            if (!prepareFin) begin
                // Any in-flight burst is abandoned; its leftover words are
                // flushed in IDLE once calibration returns.
                state <= IDLE;
                addr  <= '0;
                wcnt  <= '0;
                tcnt  <= '0;
`ifdef DDR3_READ_CHECK_EN
                expected <= 64'd1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        // Words popped here are stale and discarded.
                        if (c3_p0_rd_empty) begin
                            state <= CMD;
                        end
                    end

                    CMD: begin
                        if (!c3_p0_cmd_full) begin
                            c3_p0_cmd_en        <= 1'b1;
                            c3_p0_cmd_byte_addr <= addr;
                            wcnt                <= '0;
                            tcnt                <= '0;
                            state               <= WAIT;
                        end
                    end

                    WAIT: begin
                        if (c3_p0_rd_en) begin
                            data_out   <= c3_p0_rd_data;
                            data_valid <= 1'b1;
                            tcnt       <= '0;
`ifdef DDR3_READ_CHECK_EN
                            expected   <= expected + 64'd1;
                            if (c3_p0_rd_data != expected) begin
                                error_count <= sat_inc(error_count);
                            end
`endif
                            // Leaving WAIT on the last pop guarantees no
                            // more than BURST_LEN pops per command.
                            if (wcnt == WCNT_W'(BURST_LEN - 1)) begin
                                state <= NEXT;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
                        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                            timeout_flag <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end

                    NEXT: begin
                        if (addr_wrap) begin
                            addr      <= '0;
                            pass_done <= 1'b1;
                        end else begin
                            addr <= addr_sum[29:0];
                        end
                        state <= CMD;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr3_ise_read.sv
// ----------------------------------------------------------------------------
// tb_ddr3_ise_read
//   Directed bench for ddr3_ise_read with a small first-word-fall-through
//   read FIFO model. Runs with BURST_LEN=4, ADDR_STEP=64, ADDR_LIMIT=256 and
//   TIMEOUT=15 so that the address wrap and the timeout are reached quickly.
// ----------------------------------------------------------------------------
module tb_ddr3_ise_read;

    logic        clock = 1'b0;
    logic        reset;
    logic        prepareFin;
    logic        c3_p0_cmd_en;
    logic [2:0]  c3_p0_cmd_instr;
    logic [5:0]  c3_p0_cmd_bl;
    logic [29:0] c3_p0_cmd_byte_addr;
    logic        c3_p0_cmd_full;
    logic        c3_p0_rd_en;
    logic [63:0] c3_p0_rd_data = 64'd0;
    logic        c3_p0_rd_empty = 1'b1;
    logic        c3_p0_rd_overflow;
    logic [63:0] data_out;
    logic        data_valid;
    logic        pass_done;
    logic        timeout_flag;
    logic        overflow_flag;
    logic [15:0] error_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] fifo[$];
    logic        pop_q = 1'b0;

    always #5 clock = ~clock;

    ddr3_ise_read #(
        .BURST_LEN (4),
        .ADDR_STEP (64),
        .ADDR_LIMIT(30'd256),
        .TIMEOUT   (15)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .prepareFin         (prepareFin),
        .c3_p0_cmd_en       (c3_p0_cmd_en),
        .c3_p0_cmd_instr    (c3_p0_cmd_instr),
        .c3_p0_cmd_bl       (c3_p0_cmd_bl),
        .c3_p0_cmd_byte_addr(c3_p0_cmd_byte_addr),
        .c3_p0_cmd_full     (c3_p0_cmd_full),
        .c3_p0_rd_en        (c3_p0_rd_en),
        .c3_p0_rd_data      (c3_p0_rd_data),
        .c3_p0_rd_empty     (c3_p0_rd_empty),
        .c3_p0_rd_overflow  (c3_p0_rd_overflow),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .pass_done          (pass_done),
        .timeout_flag       (timeout_flag),
        .overflow_flag      (overflow_flag),
        .error_count        (error_count)
    );

    // FIFO model: rd_en is sampled on the falling edge, the pop happens just
    // after the rising edge, and the head/empty view is refreshed after the
    // main sequence has had a chance to push new words.
    always begin
        @(posedge clock);
        #1;
        if (pop_q && fifo.size() > 0) void'(fifo.pop_front());
        #2;
        c3_p0_rd_empty = (fifo.size() == 0);
        c3_p0_rd_data  = (fifo.size() > 0) ? fifo[0] : 64'd0;
        @(negedge clock);
        pop_q = c3_p0_rd_en;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one burst into the FIFO and check the four valid-strobed words.
    task automatic burst(input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3);
        logic [63:0] w[4];
        int n;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        n = 0;
        for (int k = 0; k < 4; k++) fifo.push_back(w[k]);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (data_valid) begin
                chk($sformatf("data_out[%0d]", n), data_out, w[n]);
                n++;
                if (n == 4) break;
            end
        end
        chk("burst_word_count", n, 4);
    endtask

    // Wait for the next command; check its address, the pass_done pulses seen
    // on the way, that no data was strobed, and that cmd_en lasts one cycle.
    task automatic wait_cmd(input logic [29:0] a, input int exp_pass);
        int pc;
        int vc;
        bit got;
        pc = 0; vc = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pass_done) pc++;
            if (data_valid) vc++;
            if (c3_p0_cmd_en) begin
                got = 1'b1;
                break;
            end
        end
        chk("cmd_seen", got, 1);
        chk("cmd_addr", c3_p0_cmd_byte_addr, a);
        chk("pass_done_count", pc, exp_pass);
        chk("stray_data_valid", vc, 0);
        tick();
        chk("cmd_en_pulse_width", c3_p0_cmd_en, 0);
    endtask

    initial begin
        int  cyc;
        bit  seen;

        reset             = 1'b1;
        prepareFin        = 1'b1;
        c3_p0_cmd_full    = 1'b0;
        c3_p0_rd_overflow = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_cmd_en", c3_p0_cmd_en, 0);
        chk("rst_cmd_addr", c3_p0_cmd_byte_addr, 0);
        chk("rst_rd_en", c3_p0_rd_en, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_timeout_flag", timeout_flag, 0);
        chk("rst_overflow_flag", overflow_flag, 0);
        chk("rst_error_count", error_count, 0);
        chk("cmd_instr", c3_p0_cmd_instr, 3'b001);
        chk("cmd_bl", c3_p0_cmd_bl, 6'd3);

        // First command two cycles after reset release
        reset = 1'b0;
        tick();
        chk("first_cmd_not_yet", c3_p0_cmd_en, 0);
        tick();
        chk("first_cmd_en", c3_p0_cmd_en, 1);
        chk("first_cmd_addr", c3_p0_cmd_byte_addr, 0);
        tick();
        chk("first_cmd_pulse", c3_p0_cmd_en, 0);

        // First burst, words 1..4
        burst(64'd1, 64'd2, 64'd3, 64'd4);
        chk("err_after_burst1", error_count, 0);

        // Command FIFO full holds off the next command
        c3_p0_cmd_full = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (c3_p0_cmd_en) seen = 1'b1;
        end
        chk("cmd_held_while_full", seen, 0);
        c3_p0_cmd_full = 1'b0;
        wait_cmd(30'd64, 0);
        burst(64'd5, 64'd6, 64'd7, 64'd8);

        // Address walk 128, 192, then wrap to 0 with one pass_done
        wait_cmd(30'd128, 0);
        burst(64'd9, 64'd10, 64'd11, 64'd12);
        wait_cmd(30'd192, 0);
        burst(64'd13, 64'd14, 64'd15, 64'd16);
        wait_cmd(30'd0, 1);

        // No data: timeout. The command was seen one tick ago, so 14 further
        // ticks make 15 waiting cycles.
        chk("timeout_flag_before", timeout_flag, 0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout_flag) begin
                cyc = i;
                break;
            end
        end
        chk("timeout_cycles", cyc, 14);

        // Stale words arriving in IDLE are flushed without data_valid, then
        // the same address is retried.
        fifo.push_back(64'hAAAA);
        fifo.push_back(64'hBBBB);
        wait_cmd(30'd0, 0);
        chk("flush_fifo_empty", fifo.size(), 0);
        chk("timeout_flag_sticky", timeout_flag, 1);
        burst(64'd17, 64'd18, 64'd19, 64'd20);
        wait_cmd(30'd64, 0);

        // prepareFin low: no pops, no commands, address returns to 0
        prepareFin = 1'b0;
        fifo.push_back(64'd99);
        tick();
        chk("rd_en_gated", c3_p0_rd_en, 0);
        tick();
        chk("cmd_en_gated", c3_p0_cmd_en, 0);
        chk("rd_en_gated2", c3_p0_rd_en, 0);
        chk("fifo_untouched", fifo.size(), 1);
        prepareFin = 1'b1;
        wait_cmd(30'd0, 0);
        chk("interrupt_flush_empty", fifo.size(), 0);

        // Pattern check after restart: one bad word
        burst(64'd1, 64'd2, 64'd7, 64'd4);
`ifdef DDR3_READ_CHECK_EN
        chk("error_count", error_count, 1);
`else
        chk("error_count", error_count, 0);
`endif

        // Sticky overflow flag
        chk("overflow_before", overflow_flag, 0);
        c3_p0_rd_overflow = 1'b1;
        tick();
        c3_p0_rd_overflow = 1'b0;
        chk("overflow_set", overflow_flag, 1);
        tick(); tick();
        chk("overflow_sticky", overflow_flag, 1);

        // Reset clears sticky flags
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_clears_timeout", timeout_flag, 0);
        chk("reset_clears_overflow", overflow_flag, 0);
        chk("reset_clears_errors", error_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
